// File: rtl/sram_controller.sv
// sram_controller
//   Multi-cycle bridge from the MEM stage to a 16-bit asynchronous SRAM.
//   Each 32-bit load or store becomes two half-word accesses, low half first.
//   Each half-word phase holds the bus for WAIT_CYCLES cycles. o_Ready drops
//   while an access is in flight, and the top level uses it to freeze the
//   pipeline.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   i_Sig_Memory_Read_Enable    load request
//   i_Sig_Memory_Write_Enable   store request (wins when both are set)
//   i_Address                   word-aligned byte address
//   i_Write_Data                store data
//   o_Read_Data                 load result; holds until the next read capture
//   o_Ready                     0 = access in progress
//   o_SRAM_Address              half-word address onto the SRAM
//   i_SRAM_DQ / o_SRAM_DQ       SRAM data bus, read and write paths
//   o_SRAM_DQ_Oe                1 = drive o_SRAM_DQ onto the pad
//   o_SRAM_WE_N / o_SRAM_OE_N   active-low write strobe / output enable
module sram_controller #(
    parameter int WAIT_CYCLES     = 2,
    parameter int ADDR_BASE       = 1024,
    parameter int SRAM_ADDR_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_Sig_Memory_Read_Enable,
    input  logic                       i_Sig_Memory_Write_Enable,
    input  logic [31:0]                i_Address,
    input  logic [31:0]                i_Write_Data,
    output logic [31:0]                o_Read_Data,
    output logic                       o_Ready,
    output logic [SRAM_ADDR_WIDTH-1:0] o_SRAM_Address,
    input  logic [15:0]                i_SRAM_DQ,
    output logic [15:0]                o_SRAM_DQ,
    output logic                       o_SRAM_DQ_Oe,
    output logic                       o_SRAM_WE_N,
    output logic                       o_SRAM_OE_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WW = SRAM_ADDR_WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [WW-1:0] word_idx;
    logic [31:0]   wdata;
    logic          op_write;
    logic          req;
    logic          in_phase;
    logic          phase_last;

    always_comb begin
        req        = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
        in_phase   = (state == LOW) || (state == HIGH);
        phase_last = (cnt == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = LOW;
            LOW:     if (phase_last) state_next = HIGH;
            HIGH:    if (phase_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            o_Read_Data <= '0;
        end else begin
            state <= state_next;
            // The counter restarts from zero whenever the state changes.
            if (state_next != state || !in_phase)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (in_phase && phase_last && !op_write) begin
                if (state == LOW)
                    o_Read_Data[15:0] <= i_SRAM_DQ;
                else
                    o_Read_Data[31:16] <= i_SRAM_DQ;
            end
        end
    end

    // The request is latched so the access does not depend on the frozen inputs.
    // Only the low word-index bits that reach the SRAM bus are kept, so
    // out-of-range addresses wrap.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            word_idx <= WW'((i_Address - 32'(ADDR_BASE)) >> 2);
            wdata    <= i_Write_Data;
            op_write <= i_Sig_Memory_Write_Enable;
        end
    end

    always_comb begin
        o_Ready        = ((state == IDLE) && !req) || (state == DONE);
        o_SRAM_Address = '0;
        o_SRAM_DQ      = '0;
        o_SRAM_DQ_Oe   = 1'b0;
        o_SRAM_WE_N    = 1'b1;
        o_SRAM_OE_N    = 1'b1;
        if (in_phase) begin
            o_SRAM_Address = {word_idx, state == HIGH};
            if (op_write) begin
                o_SRAM_DQ_Oe = 1'b1;
                o_SRAM_DQ    = (state == HIGH) ? wdata[31:16] : wdata[15:0];
                // WE_N is released on the last phase cycle, so the strobe
                // rises while the address is still stable.
                o_SRAM_WE_N  = phase_last;
            end else begin
                o_SRAM_OE_N  = 1'b0;
            end
        end
    end

endmodule
